// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2) polynomial long divider: one quotient bit per RUN cycle,
// most significant first, with a start/busy/done handshake.
module gf2_poly_divider #(
    parameter int unsigned N = 448,
    parameter int unsigned M = 224
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   dividend,
    input  logic [M-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic           div_err,
    output logic [N-M:0]   quotient,
    output logic [M-2:0]   remainder
);

    localparam int unsigned QW = N - M + 1;
    localparam int unsigned IW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [N-1:0]    r, r_next, r_sh;
    logic [M-1:0]    d;
    logic [QW-1:0]   q, q_next;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            lead;

    // Leading coefficient of the current window sits at bit idx+M-1 of R.
    always_comb begin
        r_sh   = r >> idx;
        lead   = r_sh[M-1];
        r_next = lead ? (r ^ (N'(d) << idx)) : r;
        q_next = q | (QW'(lead) << idx);
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = divisor[M-1] ? RUN : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (idx == '0) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            idx       <= '0;
            div_err   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            if (divisor[M-1]) begin
                r       <= dividend;
                q       <= '0;
                d       <= divisor;
                idx     <= IW'(N - M);
                div_err <= 1'b0;
            end else begin
                div_err   <= 1'b1;
                quotient  <= '0;
                remainder <= '0;
            end
        end else if (state == RUN) begin
            r <= r_next;
            q <= q_next;
            if (idx == '0) begin
                quotient  <= q_next;
                remainder <= r_next[M-2:0];
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
